// File: rtl/branch_ctrl_bht_pkg.sv
// Shared CPU definitions used by the branch controller and its condition
// evaluator: branch funct3 codes, control-transfer encodings and the
// 2-bit saturating counter constants with their update/predict helpers.
package branch_ctrl_bht_pkg;

  // Branch condition selectors (funct3 field of a conditional branch).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Kind of control transfer carried by the resolving instruction.
  typedef enum logic [1:0] {
    CT_NORMAL = 2'b00,
    CT_BRANCH = 2'b01,
    CT_JAL    = 2'b10,
    CT_JALR   = 2'b11
  } ctrl_t;

  // Saturating counter states: strongly/weakly not-taken, weakly/strongly taken.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Move a counter one step toward the observed outcome, holding at the ends.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

  // The upper half of the counter range predicts taken.
  function automatic logic cnt_predict(input logic [1:0] cnt);
    return (cnt >= WT);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator. Compares two XLEN-wide operands
// according to funct3; the reserved codes 010/011 report illegal and are
// treated as not taken.
module branch_cond
  import branch_ctrl_bht_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iRs1,
  input  logic [XLEN-1:0] iRs2,
  output logic            oTaken,
  output logic            oIllegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  // Base comparisons, exactly XLEN bits wide; signed uses bit XLEN-1 as sign.
  always_comb begin
    eq   = (iRs1 == iRs2);
    lt_s = ($signed(iRs1) < $signed(iRs2));
    lt_u = (iRs1 < iRs2);
  end

  // Select the outcome for the requested condition.
  // NOTE: every output gets a default before the case so no latch is inferred
  // for codes that do not assign it.
  always_comb begin
    oTaken   = 1'b0;
    oIllegal = 1'b0;
    case (iFunct3)
      F3_BEQ:  oTaken = eq;
      F3_BNE:  oTaken = ~eq;
      F3_BLT:  oTaken = lt_s;
      F3_BGE:  oTaken = ~lt_s;
      F3_BLTU: oTaken = lt_u;
      F3_BGEU: oTaken = ~lt_u;
      default: oIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl_bht.sv
// Branch controller with a bimodal branch history table.
// - Fetch side: PC-indexed lookup of a 2-bit saturating counter, prediction
//   registered one cycle later. Same-cycle lookup and update of one entry
//   returns the value held before the update.
// - Resolve side: evaluates the branch condition, raises transfer / flush /
//   illegal-funct3 flags one cycle later and trains the table on legal branches.
// Optional build macro: BRANCH_CTRL_BHT_STATS_EN adds 32-bit wrapping counters
// oBrCount (trained branch resolves) and oMissCount (mispredicts).
module branch_ctrl_bht
  import branch_ctrl_bht_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,   // power of two, 4..1024
  parameter logic [1:0]  CNT_INIT  = WNT
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iFetchValid,
  input  logic [XLEN-1:0] iFetchPC,
  output logic            oPredTaken,
  input  logic            iResValid,
  input  logic [XLEN-1:0] iResPC,
  input  logic [1:0]      iCOrigPC,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iRs1,
  input  logic [XLEN-1:0] iRs2,
  input  logic            iResPredTaken,
  output logic            oCTransf,
  output logic            oMispredict,
  output logic            oBrIllegal
`ifdef BRANCH_CTRL_BHT_STATS_EN
  ,
  output logic [31:0]     oBrCount,
  output logic [31:0]     oMissCount
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  ctrl_t            res_type;

  logic             cond_taken;
  logic             cond_illegal;
  logic             bht_upd;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];

  logic             pred_q,     pred_d;
  logic             ctransf_q,  ctransf_d;
  logic             mispred_q,  mispred_d;
  logic             illegal_q,  illegal_d;

  // Word-aligned PCs: bits [1:0] and everything above the index are not used.
  logic             unused_pc_bits;
  assign unused_pc_bits = ^{iFetchPC[XLEN-1:IDX_W+2], iFetchPC[1:0],
                            iResPC[XLEN-1:IDX_W+2],   iResPC[1:0]};

  assign fetch_idx = iFetchPC[IDX_W+1:2];
  assign res_idx   = iResPC[IDX_W+1:2];
  assign res_type  = ctrl_t'(iCOrigPC);

  branch_cond #(
    .XLEN (XLEN)
  ) u_cond (
    .iFunct3  (iFunct3),
    .iRs1     (iRs1),
    .iRs2     (iRs2),
    .oTaken   (cond_taken),
    .oIllegal (cond_illegal)
  );

  // Prediction for this cycle's lookup, read from the current table contents.
  always_comb begin
    pred_d = iFetchValid & cnt_predict(bht_q[fetch_idx]);
  end

  // Resolution flags and whether the table should be trained.
  always_comb begin
    ctransf_d = 1'b0;
    mispred_d = 1'b0;
    illegal_d = 1'b0;
    bht_upd   = 1'b0;
    if (iResValid) begin
      case (res_type)
        CT_BRANCH: begin
          illegal_d = cond_illegal;
          ctransf_d = cond_taken;
          mispred_d = cond_taken ^ iResPredTaken;
          bht_upd   = ~cond_illegal;
        end
        CT_JAL, CT_JALR: begin
          ctransf_d = 1'b1;
          mispred_d = ~iResPredTaken;
        end
        default: ;
      endcase
    end
  end

  // Next table contents: only the resolving entry can change.
  always_comb begin
    bht_d = bht_q;
    if (bht_upd) bht_d[res_idx] = cnt_next(bht_q[res_idx], cond_taken);
  end

  // Table and output registers; reset wins over any lookup or resolve.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is also what gives the lookup read-before-write.
  // NOTE: the table is reset entry by entry because the reset counter value is
  // architecturally visible through the first predictions.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_INIT;
      pred_q    <= 1'b0;
      ctransf_q <= 1'b0;
      mispred_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      bht_q     <= bht_d;
      pred_q    <= pred_d;
      ctransf_q <= ctransf_d;
      mispred_q <= mispred_d;
      illegal_q <= illegal_d;
    end
  end

  assign oPredTaken  = pred_q;
  assign oCTransf    = ctransf_q;
  assign oMispredict = mispred_q;
  assign oBrIllegal  = illegal_q;

`ifdef BRANCH_CTRL_BHT_STATS_EN
  logic [31:0] br_cnt_q,   br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Event counters; 32-bit adds wrap naturally.
  always_comb begin
    br_cnt_d   = br_cnt_q   + {31'd0, bht_upd};
    miss_cnt_d = miss_cnt_q + {31'd0, mispred_d};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      br_cnt_q   <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign oBrCount   = br_cnt_q;
  assign oMissCount = miss_cnt_q;
`endif

endmodule
